serial_byte_assembler: RTL and testbench
========================================

// Module: serial_byte_assembler
//
// PURPOSE
// Collects a serial bit stream into WIDTH-bit words and buffers them in a small FIFO.
// Presents each word on d with a valid/ready handshake.
// Sits directly upstream of the combinational byte odd/even checker; d drives its
// 8-bit input.
// Also flags framing slips (SOF mid-word) and FIFO overruns.
//
// PARAMETERS
// WIDTH      8   bits per assembled word
// MSB_FIRST  0   0: first serial bit lands in d[0]; 1: first bit lands in d[WIDTH-1]
// DEPTH      2   output FIFO entries (power of 2, >=2)
// CNT_W      8   width of drop counter
//
// PORTS
// clk        in   1                     rising-edge clock
// rst_n      in   1                     asynchronous active-low reset
// bit_in     in   1                     serial data bit
// bit_valid  in   1                     bit_in sampled this cycle
// sof        in   1                     start of frame: next bit (or this one) is bit 0
// d          out  WIDTH                 FIFO head word
// d_valid    out  1                     FIFO non-empty
// d_ready    in   1                     consumer accepts d this cycle
// level      out  $clog2(DEPTH)+1       FIFO occupancy
// sync_err   out  1                     1-cycle pulse: partial word discarded by sof
// overrun    out  1                     sticky: a word was dropped on full FIFO
// drop_cnt   out  CNT_W                 saturating count of dropped words
//
// BEHAVIOUR
// - Reset (async assert, sync-released on clk): bit counter=0, shift reg=0, FIFO empty.
//   Outputs at reset: d=0, d_valid=0, level=0, sync_err=0, overrun=0, drop_cnt=0.
// - Bit counter idx 0..WIDTH-1 advances only on bit_valid.
//   Bit placement: position idx if MSB_FIRST=0, WIDTH-1-idx if MSB_FIRST=1.
// - Word complete when bit_valid and idx==WIDTH-1.
//   The full word (including this bit) is pushed at that same edge.
//   idx wraps to 0 and the shift reg clears.
//   d_valid rises the cycle after the last bit is sampled (latency 1 from last bit).
// - sof && bit_valid: bit_in becomes bit 0 of a new word (idx -> 1).
// - sof && !bit_valid: idx -> 0.
//   In both cases, any partial word (idx!=0) is discarded and sync_err pulses next cycle.
//   sof with idx==0: no sync_err.
// - sof on the bit that would complete a word: treated as new word bit 0.
//   No push; sync_err pulses.
// - FIFO: pop when d_valid && d_ready; push on word complete.
//   d and d_valid are registered from the FIFO head.
//   While d_valid && !d_ready, d holds stable.
//   Simultaneous push+pop: both occur, level unchanged, order preserved (FIFO).
//   Push when level==DEPTH with a pop in the same cycle: accepted, not dropped.
//   Push when level==DEPTH with no pop: word dropped.
//   On a drop, overrun sets and stays set until reset.
//   On a drop, drop_cnt increments, saturating at 2^CNT_W-1.
//   Pointers wrap modulo DEPTH; level is exact 0..DEPTH.
// - d_ready while empty: no effect.
// - Reset mid-word or mid-handshake: partial word and all FIFO contents lost.
//   Outputs return to reset values immediately on rst_n low.
//
// TESTING
// 1. Reset, then 8 bits LSB-first of 0x0C with d_ready=1:
//    d_valid=1 for 1 cycle with d=0x0C, one cycle after bit 8.
// 2. MSB_FIRST=1, serial 0,1,0,1,0,1,0,0:
//    d=0x54; the downstream checker sees 0x54.
// 3. d_ready=0, send 0x00, 0x01, 0xFF:
//    level=2, d=0x00 held, overrun=1, drop_cnt=1.
//    Then d_ready=1: 0x00, then 0x01 out, then empty.
// 4. 5 bits, then sof with bit_valid, then 7 more bits of 0xA5:
//    sync_err single pulse; d=0xA5; no partial word emitted.
// 5. FIFO full (d_ready=0), then last bit arrives in the same cycle as d_ready=1:
//    no drop; level stays 2; overrun stays 0.
// 6. rst_n low mid-word at idx=4 with level=1:
//    d_valid=0 and level=0 immediately.
//    After release, the next 8 bits form a clean word.

Source files
------------

// File: rtl/serial_byte_assembler.sv
// -----------------------------------------------------------------------------
// serial_byte_assembler
//
// Purpose:
//   Assembles a serial bit stream into WIDTH-bit words and queues them in a
//   small FIFO. The FIFO head is presented on d with a valid/ready handshake.
//   The block also flags framing slips, where sof arrives mid-word, and FIFO
//   overruns, which are sticky and counted.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   bit_in     in   1          serial data bit
//   bit_valid  in   1          bit_in is sampled this cycle
//   sof        in   1          start of frame; this bit (if valid) is bit 0
//   d          out  WIDTH      FIFO head word (registered)
//   d_valid    out  1          FIFO non-empty (registered)
//   d_ready    in   1          consumer accepts d this cycle
//   level      out  LVL_W      FIFO occupancy, 0..DEPTH
//   sync_err   out  1          one-cycle pulse: partial word discarded by sof
//   overrun    out  1          sticky: a word was dropped on a full FIFO
//   drop_cnt   out  CNT_W      saturating count of dropped words
// -----------------------------------------------------------------------------
module serial_byte_assembler #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 8,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] d,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [LVL_W-1:0] level,
  output logic             sync_err,
  output logic             overrun,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  // Registered state
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_d;
  logic             r_d_valid;
  logic             r_sync_err;
  logic             r_overrun;
  logic [CNT_W-1:0] r_drop_cnt;

  // Combinational next-state values
  logic [IDX_W-1:0] w_pos;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_first_mask;
  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_drop;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_idx_next;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_sync_next;
  logic [PTR_W-1:0] w_rd_next;
  logic [PTR_W-1:0] w_wr_next;
  logic [LVL_W-1:0] w_level_next;
  logic [WIDTH-1:0] w_head_next;
  logic             w_valid_next;

  // Bit placement for the current index and for bit 0 of a new frame
  always_comb begin
    w_pos        = r_idx;
    w_first_mask = {{(WIDTH-1){1'b0}}, 1'b1};
    if (MSB_FIRST != 0) begin
      w_pos        = IDX_W'(WIDTH - 1) - r_idx;
      w_first_mask = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      w_pos        = r_idx;
      w_first_mask = {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign w_mask = {{(WIDTH-1){1'b0}}, 1'b1} << w_pos;
  assign w_word = bit_in ? (r_shift | w_mask) : r_shift;
  assign w_last = (r_idx == IDX_W'(WIDTH - 1));

  // A sof on the completing bit restarts the frame instead of pushing.
  assign w_push  = bit_valid && !sof && w_last;
  assign w_pop   = r_d_valid && d_ready;
  assign w_full  = (r_level == LVL_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_wr_en = w_push && !w_drop;

  // Bit counter, shift register and framing-slip detection
  always_comb begin
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_sync_next  = 1'b0;
    if (sof) begin
      w_sync_next = (r_idx != '0);
      if (bit_valid) begin
        w_idx_next   = IDX_W'(1);
        w_shift_next = bit_in ? w_first_mask : '0;
      end else begin
        w_idx_next   = '0;
        w_shift_next = '0;
      end
    end else if (bit_valid) begin
      if (w_last) begin
        w_idx_next   = '0;
        w_shift_next = '0;
      end else begin
        w_idx_next   = r_idx + IDX_W'(1);
        w_shift_next = w_word;
      end
    end else begin
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
    end
  end

  assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
  assign w_wr_next    = r_wr_ptr + PTR_W'(w_wr_en);
  assign w_level_next = r_level + LVL_W'(w_wr_en) - LVL_W'(w_pop);
  assign w_valid_next = (w_level_next != '0);

  // Head word after this edge; a write landing on the new head bypasses r_mem.
  always_comb begin
    w_head_next = r_d;
    if (!w_valid_next) begin
      w_head_next = r_d;
    end else if (w_wr_en && (r_wr_ptr == w_rd_next)) begin
      w_head_next = w_word;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // Assembler state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_shift    <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_idx      <= w_idx_next;
      r_shift    <= w_shift_next;
      r_sync_err <= w_sync_next;
    end
  end

  // FIFO storage, pointers and registered head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_d       <= '0;
      r_d_valid <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_word;
      end
      r_wr_ptr  <= w_wr_next;
      r_rd_ptr  <= w_rd_next;
      r_level   <= w_level_next;
      r_d       <= w_head_next;
      r_d_valid <= w_valid_next;
    end
  end

  // Overrun flag and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (r_drop_cnt != {CNT_W{1'b1}}) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign d        = r_d;
  assign d_valid  = r_d_valid;
  assign level    = r_level;
  assign sync_err = r_sync_err;
  assign overrun  = r_overrun;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// -----------------------------------------------------------------------------
// tb_serial_byte_assembler
//
// Purpose:
//   Directed, self-checking bench for serial_byte_assembler. A reference model
//   of bit assembly, FIFO occupancy and error flags runs alongside the
//   stimulus. Expected words go into a scoreboard queue at the edge that
//   completes them, and leave it when the model sees a handshake. A second
//   instance covers MSB-first placement.
// -----------------------------------------------------------------------------
module tb_serial_byte_assembler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in, bit_valid, sof, d_ready;
  logic [7:0] d;
  logic       d_valid;
  logic [1:0] level;
  logic       sync_err, overrun;
  logic [7:0] drop_cnt;

  logic       bit_in2, bit_valid2;
  logic [7:0] d2;
  logic       d_valid2;
  logic [1:0] level2;
  logic       sync_err2, overrun2;
  logic [7:0] drop_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q[$];
  int         mlevel;
  int         midx;
  logic [7:0] mword;
  logic       msync;
  logic       mover;
  int         mdrop;

  always #5 clk = ~clk;

  serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(0), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .d(d), .d_valid(d_valid), .d_ready(d_ready), .level(level),
    .sync_err(sync_err), .overrun(overrun), .drop_cnt(drop_cnt)
  );

  serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1), .DEPTH(2), .CNT_W(8)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in2), .bit_valid(bit_valid2), .sof(1'b0),
    .d(d2), .d_valid(d_valid2), .d_ready(1'b1), .level(level2),
    .sync_err(sync_err2), .overrun(overrun2), .drop_cnt(drop_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mlevel = 0;
    midx   = 0;
    mword  = 8'h00;
    msync  = 1'b0;
    mover  = 1'b0;
    mdrop  = 0;
  endtask

  // Assert reset asynchronously, check outputs at once, then release on a negedge.
  task automatic do_reset();
    bit_valid = 1'b0; bit_in = 1'b0; sof = 1'b0; d_ready = 1'b0;
    bit_valid2 = 1'b0; bit_in2 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive inputs, check outputs on the negedge, advance the model.
  task automatic step(input logic bv, input logic b, input logic s, input logic rdy);
    logic       pop, comp, full;
    logic [7:0] w;
    bit_valid = bv; bit_in = b; sof = s; d_ready = rdy;
    @(negedge clk);
    check("d_valid", 32'(d_valid), 32'(mlevel != 0));
    check("level", 32'(level), 32'(mlevel));
    check("sync_err", 32'(sync_err), 32'(msync));
    check("overrun", 32'(overrun), 32'(mover));
    check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    if (mlevel != 0) begin
      check("d_head", 32'(d), 32'(q[0]));
    end
    pop  = (mlevel != 0) && rdy;
    full = (mlevel == 2) && !pop;
    comp = bv && !s && (midx == 7);
    w = mword;
    w[midx] = b;
    msync = s && (midx != 0);
    if (s) begin
      mword = 8'h00;
      if (bv) begin
        mword[0] = b;
        midx = 1;
      end else begin
        midx = 0;
      end
    end else if (bv) begin
      if (midx == 7) begin
        midx  = 0;
        mword = 8'h00;
      end else begin
        mword[midx] = b;
        midx++;
      end
    end
    if (pop) begin
      void'(q.pop_front());
      mlevel--;
    end
    if (comp) begin
      if (full) begin
        mover = 1'b1;
        if (mdrop < 255) mdrop++;
      end else begin
        q.push_back(w);
        mlevel++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Send bits [first..last] of w LSB-first; the final bit uses rdy_last.
  task automatic send_bits(input logic [7:0] w, input int first, input int last,
                           input logic rdy, input logic rdy_last);
    for (int i = first; i <= last; i++) begin
      step(1'b1, w[i], 1'b0, (i == last) ? rdy_last : rdy);
    end
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0;
    model_clear();

    // 1: LSB-first 0x0C, one-cycle valid pulse with d_ready held high
    do_reset();
    send_bits(8'h0C, 0, 7, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // sof while idle at bit 0: no slip reported
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 2: MSB-first instance, serial 0,1,0,1,0,1,0,0 -> 0x54
    pat = 8'b0010_1010;
    for (int i = 0; i < 8; i++) begin
      bit_valid2 = 1'b1;
      bit_in2 = pat[i];
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    bit_valid2 = 1'b0;
    check("msb_d_valid", 32'(d_valid2), 32'd1);
    check("msb_d", 32'(d2), 32'h54);
    check("msb_odd_parity", 32'(^d2), 32'd1);

    // 3: stalled consumer, third word overruns, then drain
    do_reset();
    send_bits(8'h00, 0, 7, 1'b0, 1'b0);
    send_bits(8'h01, 0, 7, 1'b0, 1'b0);
    send_bits(8'hFF, 0, 7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 5: full FIFO, last bit coincides with the pop: no drop
    do_reset();
    send_bits(8'h11, 0, 7, 1'b0, 1'b0);
    send_bits(8'h22, 0, 7, 1'b0, 1'b0);
    send_bits(8'h33, 0, 7, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 4: five bits, then sof with a valid bit restarts the frame as 0xA5
    send_bits(8'h1F, 0, 4, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    send_bits(8'hA5, 1, 7, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // sof without a valid bit mid-word, then sof on the completing bit
    send_bits(8'h07, 0, 2, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(8'h5A, 0, 6, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    send_bits(8'hC3, 1, 7, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 6: reset mid-word with one word queued, then a clean word
    do_reset();
    send_bits(8'h3C, 0, 7, 1'b0, 1'b0);
    send_bits(8'hF0, 0, 3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_bits(8'h96, 0, 7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
